// File: rtl/secuenciador_suma_multipalabra.sv
// Multi-word add/subtract sequencer that time-shares one external 32-bit adder, least-significant word first.
// Latency inicio->listo = NUM_PALABRAS+1 cycles; inicio is ignored while ocupado (no queueing).
module secuenciador_suma_multipalabra #(
    parameter  int NUM_PALABRAS = 4,
    localparam int W            = 32 * NUM_PALABRAS,
    localparam int IDX_W        = (NUM_PALABRAS > 1) ? $clog2(NUM_PALABRAS) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inicio,
    input  logic         resta,
    input  logic [W-1:0] OperandoA,
    input  logic [W-1:0] OperandoB,
    output logic [31:0]  SumandoA,
    output logic [31:0]  SumandoB,
    output logic         Acarreo,
    input  logic [31:0]  Resultado,
    input  logic         SignoMasSignificativo,
    output logic [W-1:0] ResultadoFinal,
    output logic         AcarreoFinal,
    output logic         Desborde,
    output logic         ocupado,
    output logic         listo
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUMA   = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_PALABRAS - 1);

    estado_t                           estado_q, estado_d;
    logic [NUM_PALABRAS-1:0][31:0]     a_q, a_d;
    logic [NUM_PALABRAS-1:0][31:0]     b_q, b_d;
    logic [NUM_PALABRAS-1:0][31:0]     res_q, res_d;
    logic                              resta_q, resta_d;
    logic [IDX_W-1:0]                  indice_q, indice_d;
    logic                              carry_q, carry_d;
    logic                              acf_q, acf_d;
    logic                              des_q, des_d;
    logic [31:0]                       b_palabra;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= REPOSO;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            resta_q  <= 1'b0;
            indice_q <= '0;
            carry_q  <= 1'b0;
            acf_q    <= 1'b0;
            des_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            resta_q  <= resta_d;
            indice_q <= indice_d;
            carry_q  <= carry_d;
            acf_q    <= acf_d;
            des_q    <= des_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        resta_d   = resta_q;
        indice_d  = indice_q;
        carry_d   = carry_q;
        acf_d     = acf_q;
        des_d     = des_q;
        b_palabra = '0;
        SumandoA  = '0;
        SumandoB  = '0;
        Acarreo   = 1'b0;
        ocupado   = 1'b0;
        listo     = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    a_d      = OperandoA;
                    b_d      = OperandoB;
                    resta_d  = resta;
                    indice_d = '0;
                    carry_d  = resta;
                    estado_d = SUMA;
                end
            end
            SUMA: begin
                ocupado   = 1'b1;
                b_palabra = b_q[indice_q] ^ {32{resta_q}};
                SumandoA  = a_q[indice_q];
                SumandoB  = b_palabra;
                Acarreo   = carry_q;
                res_d[indice_q] = Resultado;
                carry_d   = SignoMasSignificativo;
                if (indice_q == ULTIMO) begin
                    // Flags registered on entry to FIN so they are valid while listo is high.
                    acf_d    = SignoMasSignificativo;
                    des_d    = (a_q[NUM_PALABRAS-1][31] == b_palabra[31]) &&
                               (Resultado[31] != a_q[NUM_PALABRAS-1][31]);
                    estado_d = FIN;
                end else begin
                    indice_d = indice_q + 1'b1;
                end
            end
            FIN: begin
                ocupado  = 1'b1;
                listo    = 1'b1;
                estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    assign ResultadoFinal = res_q;
    assign AcarreoFinal   = acf_q;
    assign Desborde       = des_q;

endmodule
